instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage of the single-issue pipelined CPU. Holds the program counter, fetches instruction words from instruction memory over a req/ack handshake that tolerates wait states, and drives the instruction word and PC+4 into the IF/ID pipeline register. Because the IF/ID register captures every clock with no enable, this block implements stall (re-present the same instruction) and redirect/flush (branch/jump, with wrong-path responses discarded).

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- CLK  in  1  pipeline clock; all state updates on rising edge
- RST_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold the presented instruction this cycle
- redirect  in  1  one-cycle pulse: taken branch/jump resolved downstream
- redirect_target  in  32  new PC, valid with redirect; word-aligned
- imem_req  out  1  fetch request; once high, held with imem_addr stable until imem_ack
- imem_addr  out  32  fetch address (current PC)
- imem_ack  in  1  response strobe; may arrive in the same cycle as imem_req or later
- imem_rdata  in  32  instruction word, valid with imem_ack
- entireOpCode  out  32  instruction to IF/ID; 32'h0000_0000 (NOP) when inst_valid=0
- newAddress  out  32  PC+4 of the presented instruction
- inst_valid  out  1  presented instruction is real (0 = bubble)

## Operation
- Registers: pc, buf_valid, buf_inst, buf_pc4, state ∈ {IDLE, WAIT, DROP}.
- Reset: pc=RESET_PC, state=IDLE, buf_valid=0, buf_inst=0, buf_pc4=0; so entireOpCode=0, newAddress=0, inst_valid=0. An outstanding memory request is abandoned; imem_req drops asynchronously.
- Outputs: entireOpCode = buf_valid ? buf_inst : 0; newAddress = buf_pc4; inst_valid = buf_valid.
- Buffer consumed at an edge when buf_valid & !stall.
- IDLE: imem_req = !buf_valid | !stall, imem_addr = pc. Issued with no ack → WAIT.
- WAIT: imem_req=1 regardless of stall; imem_addr=pc.
- Accepted ack (IDLE issuing or WAIT, no redirect): buf_inst<=imem_rdata, buf_pc4<=pc+4, buf_valid<=1, pc<=pc+4, state→IDLE. Invariant: at most one outstanding request, and the buffer is empty or draining whenever an ack is accepted.
- Consume with no accepted ack: buf_valid<=0.
- Redirect (priority over stall and ack): buf_valid<=0, pc<=redirect_target. If a request is outstanding or being issued this cycle without ack → DROP; otherwise → IDLE. A same-cycle ack is discarded.
- DROP: imem_req=1, imem_addr = old address, held in a separate drop_addr register because pc has already been updated. On ack, discard data → IDLE. A further redirect in DROP updates pc only.
- Arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- First imem_req in the first cycle after RST_n deasserts.
- Zero-wait memory: instruction presented the cycle after its ack; sustained throughput 1 instruction/cycle with stall=0.
- N wait states: each fetch adds N bubble cycles (inst_valid=0).
- Redirect in cycle t: outputs are a bubble at t+1; the target instruction is presented ≥1 cycle after its ack.
- stall only holds the presented outputs; it never retracts an asserted request.

## Structure
- Shared package cpu_pkg: NOP_OPCODE = 32'h0000_0000, PC_INCR = 4, fetch state encoding, default RESET_PC.
- One natural sub-module: fetch_buffer (single-entry buffer with fill/drain/flush). The FSM and pc live at top level.

## Test plan
- Reset with RESET_PC=32'h0000_0100, zero-wait memory → imem_addr 0x100, 0x104, 0x108 on consecutive cycles; newAddress 0x104, 0x108, 0x10C one cycle later, with inst_valid=1 each cycle.
- 2-wait-state memory → imem_req held high with a stable address for 3 cycles per fetch; 2 bubbles (entireOpCode=0, inst_valid=0) between instructions.
- stall high 3 cycles while 0x8C220004 is presented → the same opcode and newAddress are held for 4 cycles; no second request is issued while the buffer is full; the next fetch resumes after stall falls.
- redirect to 0x0000_0400 while a 0x110 request waits on ack → req/addr 0x110 held until ack; data discarded (inst_valid stays 0); the next request is at 0x400.
- redirect and stall in the same cycle as an ack → the buffer is flushed, the ack data is dropped, and pc=target.
- RST_n pulsed low mid-WAIT → outputs immediately go to 0 and imem_req to 0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/PC constants and the fetch FSM state encoding.
package cpu_pkg;

  localparam logic [31:0] NOP_OPCODE       = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata
  );

endinterface

// File: rtl/fetch_buffer.sv
// Single-entry instruction buffer feeding IF/ID; flush beats fill, fill beats drain.
module fetch_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fill,
  input  logic [31:0] fill_inst,
  input  logic [31:0] fill_pc4,
  input  logic        drain,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc4
);

  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_d = valid_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (fill) begin
      valid_d = 1'b1;
      inst_d  = fill_inst;
      pc4_d   = fill_pc4;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC, req/ack fetch FSM with wrong-path drop, and the IF/ID-facing buffer.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                      CLK,
  input  logic                      RST_n,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [31:0]               redirect_target,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               entireOpCode,
  output logic [31:0]               newAddress,
  output logic                      inst_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;

  logic         req_raw;
  logic [31:0]  fetch_addr;
  logic         accept;
  logic         buf_valid;
  logic [31:0]  buf_inst;
  logic [31:0]  buf_pc4;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // A response to a request made before a redirect belongs to the wrong path.
  assign accept = req_raw & imem.imem_ack & (state_q != FETCH_DROP) & ~redirect;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    if (redirect) begin
      pc_d = redirect_target;
      if (req_raw && !imem.imem_ack) begin
        state_d     = FETCH_DROP;
        drop_addr_d = fetch_addr;
      end else begin
        state_d = FETCH_IDLE;
      end
    end else begin
      unique case (state_q)
        FETCH_IDLE: begin
          if (req_raw && imem.imem_ack) pc_d = pc_q + PC_INCR;
          else if (req_raw)             state_d = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem.imem_ack) begin
            pc_d    = pc_q + PC_INCR;
            state_d = FETCH_IDLE;
          end
        end
        FETCH_DROP: begin
          if (imem.imem_ack) state_d = FETCH_IDLE;
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_comb begin
    req_raw    = 1'b0;
    fetch_addr = pc_q;
    unique case (state_q)
      FETCH_IDLE: req_raw = ~buf_valid | ~stall;
      FETCH_WAIT: req_raw = 1'b1;
      FETCH_DROP: begin
        req_raw    = 1'b1;
        fetch_addr = drop_addr_q;
      end
      default: req_raw = 1'b0;
    endcase
  end

  // Gating with RST_n abandons an outstanding request the moment reset asserts.
  assign imem.imem_req  = req_raw & RST_n;
  assign imem.imem_addr = fetch_addr;

  fetch_buffer u_fetch_buffer (
    .clk       (CLK),
    .rst_n     (RST_n),
    .fill      (accept),
    .fill_inst (imem.imem_rdata),
    .fill_pc4  (pc_q + PC_INCR),
    .drain     (buf_valid & ~stall),
    .flush     (redirect),
    .valid     (buf_valid),
    .inst      (buf_inst),
    .pc4       (buf_pc4)
  );

  assign entireOpCode = buf_valid ? buf_inst : NOP_OPCODE;
  assign newAddress   = buf_pc4;
  assign inst_valid   = buf_valid;

endmodule
